layer_load_scheduler: RTL
=========================

# layer_load_scheduler

Sequences one full network pass through the PE array: fetches the per-layer weight words and the layer-0 input rows from a single-ported on-chip buffer, then drives the array's compute enables for every input row. Sits between the top-level start/done interface and the PE array, replacing hand-driven load/compute sequencing. It is the only master of the buffer read port during a pass.

## Interface
- DATA_W, 64, width of one buffer word (one weight row or one input row)
- ADDR_W, 8, buffer address width
- WEIGHT_BASE, 0, buffer address of layer-0 weight word 0
- INPUT_BASE, 64, buffer address of input row 0
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- start_i  input  1  one-cycle pulse that starts a pass; ignored unless in IDLE
- array_ready_i  input  1  array can accept a new step; low = stall
- mem_rd_en_o  output  1  buffer read strobe
- mem_addr_o  output  ADDR_W  buffer read address
- mem_rdata_i  input  DATA_W  buffer read data, valid exactly 1 cycle after mem_rd_en_o
- data_o  output  DATA_W  registered copy of mem_rdata_i
- weight_valid_o  output  1  data_o is weight word weight_o
- input_valid_o  output  1  data_o is input row row_o
- input_sel_o  output  1  0 = array takes input from data_o, 1 = from its own previous-layer result
- compute_en_o  output  1  array performs one MAC step with weight_o
- layer_o  output  3  current layer, 0-7
- row_o  output  4  current input row, 0-15
- weight_o  output  3  weight index being loaded or applied, 0-7
- result_valid_o  output  1  final-layer result of row_o is complete
- busy_o  output  1  high from the cycle after start_i until done_o
- done_o  output  1  one-cycle pulse at end of pass

## Operation
- States: IDLE, LOAD_W, LOAD_I, COMPUTE, DONE.
- IDLE: all outputs 0, counters 0. start_i=1 -> LOAD_W.
- LOAD_W: one read per cycle, addr = WEIGHT_BASE + layer*8 + w, w = 0..7. After w=7 -> LOAD_I if layer=0, else COMPUTE; w resets to 0.
- LOAD_I: single read, addr = INPUT_BASE + row -> COMPUTE.
- COMPUTE: 8 cycles, compute_en_o=1, weight_o = 0..7. On w=7: if layer=7, result_valid_o=1 that cycle. Then row=15 and layer=7 -> DONE; row=15 -> row=0, layer+1, LOAD_W; else row+1, LOAD_I (layer 0) or stay in COMPUTE (layers 1-7).
- input_sel_o = 0 in layer 0, 1 in layers 1-7 (valid whenever busy_o).
- DONE: done_o=1 for one cycle, busy_o=0 -> IDLE.
- Read return: data_o, weight_valid_o, input_valid_o are registered 1 cycle after the issuing read; weight_o / row_o travel with the returned data (tag registered alongside the read).
- Address arithmetic modulo 2^ADDR_W; no overflow check.

## Timing
- Reset: every output 0, state IDLE, all counters 0, in-flight read return discarded (no valid in cycle after reset).
- start_i in cycle t -> first mem_rd_en_o and busy_o=1 in cycle t+1.
- Last weight of a layer returns in the first cycle of LOAD_I (layer 0) or first COMPUTE cycle (layers 1-7); input row returns in first COMPUTE cycle, same cycle as compute_en_o; array latches data before use.
- Unstalled pass length: layer 0 = 8 + 16*9 = 152 cycles; layers 1-7 = 8 + 16*8 = 136 each; total 1104 busy cycles, done_o in cycle t+1105.
- Stall: array_ready_i=0 in LOAD_W/LOAD_I/COMPUTE freezes state and counters, forces mem_rd_en_o=0, compute_en_o=0, result_valid_o=0. A read issued in the previous cycle still returns normally. No effect in IDLE/DONE.
- start_i while busy_o=1 or in DONE: ignored.
- rst mid-pass: IDLE next cycle, no done_o.

## Test plan
- Reset then single start_i, array_ready_i=1 -> busy_o 1104 cycles, done_o one pulse at t+1105, exactly 64 weight reads + 16 input reads, 16 result_valid_o pulses all in layer 7.
- Layer-0 addresses -> reads 0..7 then 64, then 65 after 8 compute cycles; layer 3 weight reads at 24..31; no input reads after layer 0, input_sel_o=1.
- Data/tag alignment with mem_rdata_i = address -> weight_valid_o with data_o=27 carries weight_o=3, layer_o=3; input_valid_o with data_o=70 carries row_o=6.
- array_ready_i low 5 cycles during LOAD_W at w=4 -> no reads, w stays 4, read issued before stall returns once; pass total extends by exactly 5 cycles.
- start_i pulsed at cycle 300 of a pass -> ignored, single done_o.
- rst at cycle 500 with read outstanding -> all outputs 0 next cycle, no valid returned; new start_i completes normal 1104-cycle pass.

Source files
------------

// File: rtl/layer_load_scheduler.sv
// Purpose: sequences one full network pass: weight/input fetch from the buffer, then PE-array compute enables.
// Latency: first read the cycle after start_i; read data/tags return one cycle after the read; 1104 busy cycles unstalled.
// Backpressure: array_ready_i low freezes state/counters and suppresses reads and compute; in-flight read still returns.
module layer_load_scheduler #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 8,
    parameter int WEIGHT_BASE = 0,
    parameter int INPUT_BASE  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              array_ready_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] data_o,
    output logic              weight_valid_o,
    output logic              input_valid_o,
    output logic              input_sel_o,
    output logic              compute_en_o,
    output logic [2:0]        layer_o,
    output logic [3:0]        row_o,
    output logic [2:0]        weight_o,
    output logic              result_valid_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_I  = 3'd2,
        COMPUTE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] layer_q, layer_d;
    logic [3:0] row_q, row_d;
    logic [2:0] w_q, w_d;

    // Tags of the read issued last cycle; they line up with the word the buffer returns now.
    logic       ret_w_q;
    logic       ret_i_q;
    logic [2:0] ret_widx_q;
    logic [3:0] ret_row_q;

    // State and pass counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            layer_q <= '0;
            row_q   <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            row_q   <= row_d;
            w_q     <= w_d;
        end
    end

    // Register the kind and index of each issued read so the returning word carries its tag; reset drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_w_q    <= 1'b0;
            ret_i_q    <= 1'b0;
            ret_widx_q <= '0;
            ret_row_q  <= '0;
        end else begin
            ret_w_q    <= mem_rd_en_o && (state_q == LOAD_W);
            ret_i_q    <= mem_rd_en_o && (state_q == LOAD_I);
            ret_widx_q <= w_q;
            ret_row_q  <= row_q;
        end
    end

    // Next-state, counter update, read issue and compute strobes; a low array_ready_i holds everything.
    always_comb begin
        state_d        = state_q;
        layer_d        = layer_q;
        row_d          = row_q;
        w_d            = w_q;
        mem_rd_en_o    = 1'b0;
        mem_addr_o     = '0;
        compute_en_o   = 1'b0;
        result_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD_W;
                end
            end
            LOAD_W: begin
                if (array_ready_i) begin
                    mem_rd_en_o = 1'b1;
                    mem_addr_o  = ADDR_W'(WEIGHT_BASE) + ADDR_W'({layer_q, w_q});
                    if (w_q == 3'd7) begin
                        w_d     = '0;
                        state_d = (layer_q == 3'd0) ? LOAD_I : COMPUTE;
                    end else begin
                        w_d = w_q + 3'd1;
                    end
                end
            end
            LOAD_I: begin
                if (array_ready_i) begin
                    mem_rd_en_o = 1'b1;
                    mem_addr_o  = ADDR_W'(INPUT_BASE) + ADDR_W'(row_q);
                    state_d     = COMPUTE;
                end
            end
            COMPUTE: begin
                if (array_ready_i) begin
                    compute_en_o = 1'b1;
                    if (w_q == 3'd7) begin
                        result_valid_o = (layer_q == 3'd7);
                        w_d            = '0;
                        if (row_q == 4'd15) begin
                            row_d = '0;
                            if (layer_q == 3'd7) begin
                                layer_d = '0;
                                state_d = DONE;
                            end else begin
                                layer_d = layer_q + 3'd1;
                                state_d = LOAD_W;
                            end
                        end else begin
                            row_d   = row_q + 4'd1;
                            // Only layer 0 streams rows from the buffer; later layers reuse the array's own results.
                            state_d = (layer_q == 3'd0) ? LOAD_I : COMPUTE;
                        end
                    end else begin
                        w_d = w_q + 3'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o         = (state_q == LOAD_W) || (state_q == LOAD_I) || (state_q == COMPUTE);
    assign done_o         = (state_q == DONE);
    assign input_sel_o    = busy_o && (layer_q != 3'd0);
    assign layer_o        = layer_q;
    assign weight_valid_o = ret_w_q;
    assign input_valid_o  = ret_i_q;
    // The buffer's output register is the return stage; data_o is that word, zero when nothing is returning.
    assign data_o         = (ret_w_q || ret_i_q) ? mem_rdata_i : '0;
    // A returning word shows its own tag; otherwise the live counter (the step being issued or applied).
    assign weight_o       = ret_w_q ? ret_widx_q : w_q;
    assign row_o          = ret_i_q ? ret_row_q : row_q;

endmodule
